// File: rtl/state_dump_unit_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : state_dump_unit_if
// Purpose  : valid/ready stream carrying dumped register and memory words.
// Revision : 1.0
// ============================================================================
interface state_dump_unit_if #(
    parameter int DATA_W = 32
);
    logic              out_valid;
    logic              out_ready;
    logic              out_kind;
    logic [31:0]       out_addr;
    logic [DATA_W-1:0] out_data;

    modport master (
        output out_valid,
        output out_kind,
        output out_addr,
        output out_data,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_kind,
        input  out_addr,
        input  out_data,
        output out_ready
    );
endinterface
`default_nettype wire

// File: rtl/state_dump_unit.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : state_dump_unit
// Purpose  : stops a run on halt/timeout, then streams the register file and
//            a data-memory window over a valid/ready port.
// Revision : 1.0
// ============================================================================
module state_dump_unit #(
    parameter int          DATA_W    = 32,
    parameter int          NREGS     = 32,
    parameter int          REG_AW    = 5,
    parameter logic [31:0] MEM_BASE  = 32'h1001_0000,
    parameter int          MEM_WORDS = 5,
    parameter int          TIMEOUT   = 400,
    parameter int          CNT_W     = 16
) (
    input  wire logic              clk,
    input  wire logic              reset,
    input  wire logic              halt_req,
    output logic                   freeze,
    output logic [REG_AW-1:0]      rf_raddr,
    input  wire logic [DATA_W-1:0] rf_rdata,
    output logic [31:0]            mem_addr,
    input  wire logic [DATA_W-1:0] mem_rdata,
    state_dump_unit_if.master      dump,
    output logic                   halt_cause,
    output logic [CNT_W-1:0]       cycle_count,
    output logic                   busy,
    output logic                   done
);

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_DUMP_REG = 2'd1,
        S_DUMP_MEM = 2'd2,
        S_DONE     = 2'd3
    } state_t;

    localparam logic [31:0]      c_nregs     = 32'(NREGS);
    localparam logic [31:0]      c_mem_words = 32'(MEM_WORDS);
    localparam logic [CNT_W-1:0] c_to_last   = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] c_cnt_max   = '1;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [31:0]       r_idx;
    logic [CNT_W-1:0]  r_count;
    logic              r_freeze;
    logic              r_cause;
    logic              r_done;
    logic              r_out_valid;
    logic              r_out_kind;
    logic [31:0]       r_out_addr;
    logic [DATA_W-1:0] r_out_data;

    logic              w_busy;
    logic              w_timeout;
    logic              w_exit;
    logic              w_can_load;
    logic [31:0]       w_limit;
    logic              w_load;
    logic              w_phase_end;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_busy      = (r_state == S_DUMP_REG) || (r_state == S_DUMP_MEM);
        w_timeout   = (TIMEOUT != 0) && (r_count == c_to_last);
        w_exit      = halt_req || w_timeout;
        // The output slot is free when empty or being drained this cycle.
        w_can_load  = !r_out_valid || dump.out_ready;
        w_limit     = (r_state == S_DUMP_MEM) ? c_mem_words : c_nregs;
        w_load      = w_busy && w_can_load && (r_idx < w_limit);
        w_phase_end = w_busy && w_can_load && (r_idx == w_limit);
        case (r_state)
            S_RUN: begin
                if (w_exit) begin
                    w_state_nxt = S_DUMP_REG;
                end
            end
            S_DUMP_REG: begin
                if (w_phase_end) begin
                    w_state_nxt = (MEM_WORDS == 0) ? S_DONE : S_DUMP_MEM;
                end
            end
            S_DUMP_MEM: begin
                if (w_phase_end) begin
                    w_state_nxt = S_DONE;
                end
            end
            default: w_state_nxt = S_DONE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx       <= '0;
            r_count     <= '0;
            r_freeze    <= 1'b0;
            r_cause     <= 1'b0;
            r_done      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_kind  <= 1'b0;
            r_out_addr  <= '0;
            r_out_data  <= '0;
        end else begin
            r_done <= (w_state_nxt == S_DONE);
            if (r_state == S_RUN) begin
                if (r_count != c_cnt_max) begin
                    r_count <= r_count + 1'b1;
                end
                if (w_exit) begin
                    r_freeze <= 1'b1;
                    // A coincident external halt takes precedence as the cause.
                    r_cause  <= !halt_req;
                end
            end
            if (w_load) begin
                r_out_valid <= 1'b1;
                r_out_kind  <= (r_state == S_DUMP_MEM);
                r_out_addr  <= (r_state == S_DUMP_MEM) ? mem_addr : r_idx;
                r_out_data  <= (r_state == S_DUMP_MEM) ? mem_rdata : rf_rdata;
                r_idx       <= r_idx + 32'd1;
            end else if (w_phase_end) begin
                r_out_valid <= 1'b0;
                r_idx       <= '0;
            end
        end
    end

    assign rf_raddr       = r_idx[REG_AW-1:0];
    assign mem_addr       = MEM_BASE + {r_idx[29:0], 2'b00};
    assign freeze         = r_freeze;
    assign halt_cause     = r_cause;
    assign cycle_count    = r_count;
    assign busy           = w_busy;
    assign done           = r_done;
    assign dump.out_valid = r_out_valid;
    assign dump.out_kind  = r_out_kind;
    assign dump.out_addr  = r_out_addr;
    assign dump.out_data  = r_out_data;

endmodule
`default_nettype wire

// File: tb/tb_state_dump_unit.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_state_dump_unit
// Purpose  : directed self-checking bench for state_dump_unit.
// Revision : 1.0
// ============================================================================
module tb_state_dump_unit;

    localparam logic [31:0] c_MEM_BASE = 32'h1001_0000;
    localparam logic [31:0] c_MEM_XOR  = 32'hA5A5_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b, rst_c;
    logic halt_a, halt_b, halt_c;
    logic ready;
    int   sel;
    int   n_tests = 0;
    int   n_fail  = 0;

    state_dump_unit_if #(.DATA_W(32)) if_a ();
    state_dump_unit_if #(.DATA_W(32)) if_b ();
    state_dump_unit_if #(.DATA_W(32)) if_c ();
    assign if_a.out_ready = ready;
    assign if_b.out_ready = ready;
    assign if_c.out_ready = ready;

    logic        frz_a, frz_b, frz_c, cause_a, cause_b, cause_c;
    logic        busy_a, busy_b, busy_c, done_a, done_b, done_c;
    logic [4:0]  ra_a, ra_b, ra_c;
    logic [31:0] ma_a, ma_b, ma_c;
    logic [15:0] cnt_a, cnt_b, cnt_c;

    state_dump_unit dut_a (
        .clk(clk), .reset(rst_a), .halt_req(halt_a), .freeze(frz_a),
        .rf_raddr(ra_a), .rf_rdata(32'(ra_a) * 32'd3),
        .mem_addr(ma_a), .mem_rdata(ma_a ^ c_MEM_XOR), .dump(if_a),
        .halt_cause(cause_a), .cycle_count(cnt_a), .busy(busy_a), .done(done_a)
    );

    state_dump_unit #(.TIMEOUT(20)) dut_b (
        .clk(clk), .reset(rst_b), .halt_req(halt_b), .freeze(frz_b),
        .rf_raddr(ra_b), .rf_rdata(32'(ra_b) * 32'd3),
        .mem_addr(ma_b), .mem_rdata(ma_b ^ c_MEM_XOR), .dump(if_b),
        .halt_cause(cause_b), .cycle_count(cnt_b), .busy(busy_b), .done(done_b)
    );

    state_dump_unit #(.MEM_WORDS(0), .TIMEOUT(0)) dut_c (
        .clk(clk), .reset(rst_c), .halt_req(halt_c), .freeze(frz_c),
        .rf_raddr(ra_c), .rf_rdata(32'(ra_c) * 32'd3),
        .mem_addr(ma_c), .mem_rdata(ma_c ^ c_MEM_XOR), .dump(if_c),
        .halt_cause(cause_c), .cycle_count(cnt_c), .busy(busy_c), .done(done_c)
    );

    logic        m_valid, m_kind, m_freeze, m_cause, m_busy, m_done;
    logic [31:0] m_addr, m_data;
    logic [15:0] m_cnt;

    always_comb begin
        m_valid = if_a.out_valid; m_kind = if_a.out_kind;
        m_addr  = if_a.out_addr;  m_data = if_a.out_data;
        m_freeze = frz_a; m_cause = cause_a; m_cnt = cnt_a;
        m_busy  = busy_a; m_done = done_a;
        if (sel == 1) begin
            m_valid = if_b.out_valid; m_kind = if_b.out_kind;
            m_addr  = if_b.out_addr;  m_data = if_b.out_data;
            m_freeze = frz_b; m_cause = cause_b; m_cnt = cnt_b;
            m_busy  = busy_b; m_done = done_b;
        end else if (sel == 2) begin
            m_valid = if_c.out_valid; m_kind = if_c.out_kind;
            m_addr  = if_c.out_addr;  m_data = if_c.out_data;
            m_freeze = frz_c; m_cause = cause_c; m_cnt = cnt_c;
            m_busy  = busy_c; m_done = done_c;
        end
    end

    logic        rec_kind [0:63];
    logic [31:0] rec_addr [0:63];
    logic [31:0] rec_data [0:63];
    int          n_rec;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Runs the consumer side; bp selects the 1,0,0,1 ready pattern.
    task automatic collect(input bit bp, input int stop_after, output int cycles);
        logic [3:0]  pat = 4'b1001;
        logic        pv_stall = 1'b0;
        logic        pk;
        logic [31:0] pa, pd;
        cycles = 0;
        n_rec  = 0;
        while (1) begin
            @(negedge clk);
            ready = bp ? pat[cycles % 4] : 1'b1;
            #1;
            cycles++;
            if (m_done) break;
            if (pv_stall) begin
                chk("stall_valid", m_valid, 1'b1);
                chk("stall_kind", m_kind, pk);
                chk("stall_addr", m_addr, pa);
                chk("stall_data", m_data, pd);
            end
            pv_stall = m_valid && !ready;
            pk = m_kind; pa = m_addr; pd = m_data;
            if (m_valid && ready) begin
                rec_kind[n_rec] = m_kind;
                rec_addr[n_rec] = m_addr;
                rec_data[n_rec] = m_data;
                n_rec++;
                if (n_rec == stop_after || n_rec == 64) break;
            end
            if (cycles >= 2000) begin
                n_tests++;
                n_fail++;
                $display("FAIL collect_timeout: got no done after %0d cycles, required done", cycles);
                break;
            end
        end
        ready = 1'b1;
    endtask

    task automatic verify(input int n_mem);
        logic        ek;
        logic [31:0] ea, ed;
        chk("word_count", n_rec, 32 + n_mem);
        for (int i = 0; i < n_rec && i < 32 + n_mem; i++) begin
            ek = (i >= 32);
            ea = (i < 32) ? 32'(i) : c_MEM_BASE + 32'(4 * (i - 32));
            ed = (i < 32) ? 32'(i * 3) : ea ^ c_MEM_XOR;
            chk($sformatf("w%0d_kind", i), rec_kind[i], ek);
            chk($sformatf("w%0d_addr", i), rec_addr[i], ea);
            chk($sformatf("w%0d_data", i), rec_data[i], ed);
        end
    endtask

    initial begin
        int n;
        int cyc;
        ready = 1'b1; sel = 0;
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        halt_a = 1'b0; halt_b = 1'b0; halt_c = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_valid", m_valid, 1'b0);
        chk("rst_freeze", m_freeze, 1'b0);
        chk("rst_count", m_cnt, 16'd0);
        chk("rst_busy", m_busy, 1'b0);
        chk("rst_done", m_done, 1'b0);
        chk("rst_cause", m_cause, 1'b0);
        chk("rst_kind", m_kind, 1'b0);
        chk("rst_addr", m_addr, 32'd0);
        chk("rst_data", m_data, 32'd0);

        // Watchdog expiry with an always-ready consumer.
        @(negedge clk); rst_a = 1'b0;
        n = 0;
        while (n < 1000) begin
            @(negedge clk); #1; n++;
            if (m_freeze) break;
        end
        chk("to_freeze_cycle", n, 400);
        chk("to_count", m_cnt, 16'd400);
        chk("to_cause", m_cause, 1'b1);
        chk("to_busy", m_busy, 1'b1);
        chk("to_first_valid", m_valid, 1'b0);
        collect(1'b0, 64, cyc);
        chk("to_dump_cycles", cyc, 39);
        verify(5);
        chk("to_done", m_done, 1'b1);
        chk("to_end_valid", m_valid, 1'b0);
        chk("to_end_busy", m_busy, 1'b0);
        halt_a = 1'b1;
        @(negedge clk); halt_a = 1'b0;
        @(negedge clk); #1;
        chk("done_sticky", m_done, 1'b1);
        chk("done_count_hold", m_cnt, 16'd400);

        // External halt at count 10 with back-pressure.
        rst_a = 1'b1;
        @(negedge clk); rst_a = 1'b0;
        repeat (10) @(negedge clk);
        halt_a = 1'b1;
        @(negedge clk); halt_a = 1'b0;
        #1;
        chk("halt_count", m_cnt, 16'd11);
        chk("halt_cause", m_cause, 1'b0);
        chk("halt_freeze", m_freeze, 1'b1);
        collect(1'b1, 64, cyc);
        verify(5);
        chk("bp_done", m_done, 1'b1);

        // Halt and watchdog firing on the same edge.
        sel = 1;
        @(negedge clk); rst_b = 1'b0;
        repeat (19) @(negedge clk);
        #1;
        chk("both_prefreeze", m_freeze, 1'b0);
        halt_b = 1'b1;
        @(negedge clk); halt_b = 1'b0;
        #1;
        chk("both_cause", m_cause, 1'b0);
        chk("both_count", m_cnt, 16'd20);
        chk("both_freeze", m_freeze, 1'b1);
        rst_b = 1'b1;

        // No watchdog, no memory window, counter saturation.
        sel = 2;
        @(negedge clk); rst_c = 1'b0;
        repeat (70000) @(negedge clk);
        #1;
        chk("sat_freeze", m_freeze, 1'b0);
        chk("sat_count", m_cnt, 16'hFFFF);
        halt_c = 1'b1;
        @(negedge clk); halt_c = 1'b0;
        #1;
        chk("sat_halt_freeze", m_freeze, 1'b1);
        chk("sat_halt_count", m_cnt, 16'hFFFF);
        collect(1'b0, 64, cyc);
        chk("nomem_cycles", cyc, 33);
        verify(0);
        chk("nomem_done", m_done, 1'b1);
        rst_c = 1'b1;

        // Reset in the middle of a dump, then a full replay.
        sel = 0;
        rst_a = 1'b1;
        @(negedge clk); rst_a = 1'b0; halt_a = 1'b1;
        @(negedge clk); halt_a = 1'b0;
        collect(1'b0, 7, cyc);
        chk("mid_words", n_rec, 7);
        rst_a = 1'b1;
        @(negedge clk); #1;
        chk("mid_valid", m_valid, 1'b0);
        chk("mid_freeze", m_freeze, 1'b0);
        chk("mid_count", m_cnt, 16'd0);
        chk("mid_busy", m_busy, 1'b0);
        chk("mid_done", m_done, 1'b0);
        rst_a = 1'b0; halt_a = 1'b1;
        @(negedge clk); halt_a = 1'b0;
        #1;
        chk("replay_count", m_cnt, 16'd1);
        collect(1'b0, 64, cyc);
        verify(5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
